// File: rtl/axi_ic_pkg.sv
// Shared interconnect types: write-arbiter FSM states, AXI burst and response codes.
package axi_ic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_arb_state_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  // Beat counter saturates at zero so a surplus beat cannot wrap it back to 15.
  function automatic logic [3:0] beats_dec(input logic [3:0] b);
    return (b == 4'd0) ? 4'd0 : b - 4'd1;
  endfunction

endpackage

// File: rtl/axi_wr_arbiter_2to1_if.sv
// AXI write-channel bundle (AW/W/B); master modport drives requests, slave modport answers.
interface axi_wr_arbiter_2to1_if #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int IW = 4
) ();

  logic            awvalid;
  logic [AW-1:0]   awaddr;
  logic [2:0]      awsize;
  logic [3:0]      awlen;
  logic [1:0]      awburst;
  logic [IW-1:0]   awid;
  logic            awready;

  logic            wvalid;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wready;

  logic            bvalid;
  logic [1:0]      bresp;
  logic [IW-1:0]   bid;
  logic            bready;

  modport master (
    output awvalid, awaddr, awsize, awlen, awburst, awid,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    input  awready, wready, bvalid, bresp, bid
  );

  modport slave (
    input  awvalid, awaddr, awsize, awlen, awburst, awid,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    output awready, wready, bvalid, bresp, bid
  );

endinterface

// File: rtl/axi_wr_arbiter_2to1_rr_arb2.sv
// Combinational 2-way round-robin picker: on a tie the master that did not win last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) grant = ~last;
    else              grant = req[1];
  end

endmodule

// File: rtl/axi_wr_arbiter_2to1.sv
// 2:1 AXI write arbiter: one transaction in flight, W locked to the grant until WLAST,
// B routed by grant, sticky ERR on beat-count or BID mismatches.
module axi_wr_arbiter_2to1
  import axi_ic_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int ID_SIZE = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  axi_wr_arbiter_2to1_if.slave   m0,
  axi_wr_arbiter_2to1_if.slave   m1,
  axi_wr_arbiter_2to1_if.master  s,
  output logic                   ERR
);

  wr_arb_state_e state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [3:0]    beats_left_q, beats_left_d;
  logic          err_q, err_d;

  logic          pick;
  logic          g_awvalid, g_wvalid, g_wlast, g_bready;
  logic          s_awvalid_c, s_wvalid_c, s_bready_c;
  logic          aw_ready_c, w_ready_c, b_valid_c;

  logic [AW-1:0]      awaddr_mux;
  logic [DW-1:0]      wdata_mux;
  logic [DW/8-1:0]    wstrb_mux;
  logic [ID_SIZE-1:0] awid_mux;

  rr_arb2 u_rr (
    .req   ({m1.awvalid, m0.awvalid}),
    .last  (last_q),
    .grant (pick)
  );

  assign g_awvalid  = grant_q ? m1.awvalid : m0.awvalid;
  assign g_wvalid   = grant_q ? m1.wvalid  : m0.wvalid;
  assign g_wlast    = grant_q ? m1.wlast   : m0.wlast;
  assign g_bready   = grant_q ? m1.bready  : m0.bready;
  assign awaddr_mux = grant_q ? m1.awaddr  : m0.awaddr;
  assign awid_mux   = grant_q ? m1.awid    : m0.awid;
  assign wdata_mux  = grant_q ? m1.wdata   : m0.wdata;
  assign wstrb_mux  = grant_q ? m1.wstrb   : m0.wstrb;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    beats_left_d = beats_left_q;
    err_d        = err_q;
    s_awvalid_c  = 1'b0;
    s_wvalid_c   = 1'b0;
    s_bready_c   = 1'b0;
    aw_ready_c   = 1'b0;
    w_ready_c    = 1'b0;
    b_valid_c    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (m0.awvalid || m1.awvalid) begin
          grant_d      = pick;
          beats_left_d = pick ? m1.awlen : m0.awlen;
          state_d      = ST_ADDR;
        end
      end
      ST_ADDR: begin
        s_awvalid_c = g_awvalid;
        aw_ready_c  = s.awready;
        if (g_awvalid && s.awready) state_d = ST_DATA;
      end
      ST_DATA: begin
        s_wvalid_c = g_wvalid;
        w_ready_c  = s.wready;
        if (g_wvalid && s.wready) begin
          // WLAST must coincide exactly with the final counted beat
          if (g_wlast != (beats_left_q == 4'd0)) err_d = 1'b1;
          beats_left_d = beats_dec(beats_left_q);
          if (g_wlast) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        b_valid_c  = s.bvalid;
        s_bready_c = g_bready;
        if (s.bvalid && (s.bid[ID_SIZE] != grant_q)) err_d = 1'b1;
        if (s.bvalid && g_bready) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_q       <= 1'b1;
      beats_left_q <= 4'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      beats_left_q <= beats_left_d;
      err_q        <= err_d;
    end
  end

  assign s.awvalid = s_awvalid_c;
  assign s.awaddr  = awaddr_mux;
  assign s.awsize  = grant_q ? m1.awsize  : m0.awsize;
  assign s.awlen   = grant_q ? m1.awlen   : m0.awlen;
  assign s.awburst = grant_q ? m1.awburst : m0.awburst;
  assign s.awid    = {grant_q, awid_mux};
  assign s.wvalid  = s_wvalid_c;
  assign s.wdata   = wdata_mux;
  assign s.wstrb   = wstrb_mux;
  assign s.wlast   = g_wlast;
  assign s.bready  = s_bready_c;

  assign m0.awready = aw_ready_c & ~grant_q;
  assign m1.awready = aw_ready_c &  grant_q;
  assign m0.wready  = w_ready_c  & ~grant_q;
  assign m1.wready  = w_ready_c  &  grant_q;
  assign m0.bvalid  = b_valid_c  & ~grant_q;
  assign m1.bvalid  = b_valid_c  &  grant_q;
  assign m0.bresp   = s.bresp;
  assign m1.bresp   = s.bresp;
  assign m0.bid     = s.bid[ID_SIZE-1:0];
  assign m1.bid     = s.bid[ID_SIZE-1:0];

  assign ERR = err_q;

endmodule

// File: tb/tb_axi_wr_arbiter_2to1.sv
// Directed bench for axi_wr_arbiter_2to1: round-robin vector table plus burst/response/error sequences.
module tb_axi_wr_arbiter_2to1;
  import axi_ic_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic err;
  always #5 clk = ~clk;

  axi_wr_arbiter_2to1_if #(.DW(32), .AW(32), .IW(4)) m0_if ();
  axi_wr_arbiter_2to1_if #(.DW(32), .AW(32), .IW(4)) m1_if ();
  axi_wr_arbiter_2to1_if #(.DW(32), .AW(32), .IW(5)) s_if ();

  axi_wr_arbiter_2to1 #(.DW(32), .AW(32), .ID_SIZE(4)) dut (
    .CLK (clk),
    .RST (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if),
    .ERR (err)
  );

  int checks   = 0;
  int failures = 0;

  // ctrl bits: s_awvalid s_wvalid s_bready m0_awready m1_awready m0_wready m1_wready m0_bvalid m1_bvalid err
  typedef struct {
    logic        aw0;
    logic        aw1;
    logic        bvalid;
    logic [4:0]  bid;
    logic [9:0]  exp_ctrl;
    logic [4:0]  exp_awid;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mkv(logic a0, logic a1, logic bv, logic [4:0] bid,
                               logic [9:0] c, logic [4:0] id, logic [31:0] wd);
    vec_t v;
    v.aw0 = a0; v.aw1 = a1; v.bvalid = bv; v.bid = bid;
    v.exp_ctrl = c; v.exp_awid = id; v.exp_wdata = wd;
    return v;
  endfunction

  function automatic logic [9:0] ctrl();
    return {s_if.awvalid, s_if.wvalid, s_if.bready, m0_if.awready, m1_if.awready,
            m0_if.wready, m1_if.wready, m0_if.bvalid, m1_if.bvalid, err};
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    m0_if.awvalid = 1'b0; m0_if.awaddr = 32'h0000_1000; m0_if.awsize = 3'd2;
    m0_if.awlen = 4'd0; m0_if.awburst = BURST_INCR; m0_if.awid = 4'h3;
    m0_if.wvalid = 1'b0; m0_if.wdata = 32'hA0A0_0000; m0_if.wstrb = 4'hF;
    m0_if.wlast = 1'b0; m0_if.bready = 1'b0;
    m1_if.awvalid = 1'b0; m1_if.awaddr = 32'h0000_2000; m1_if.awsize = 3'd2;
    m1_if.awlen = 4'd0; m1_if.awburst = BURST_INCR; m1_if.awid = 4'h5;
    m1_if.wvalid = 1'b0; m1_if.wdata = 32'hB0B0_0000; m1_if.wstrb = 4'hF;
    m1_if.wlast = 1'b0; m1_if.bready = 1'b0;
    s_if.awready = 1'b0; s_if.wready = 1'b0; s_if.bvalid = 1'b0;
    s_if.bresp = RESP_OKAY; s_if.bid = 5'd0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("reset_ctrl", ctrl(), 10'b0);
  endtask

  // Request on master m; leaves the DUT in DATA with awvalid dropped.
  task automatic issue_aw(input int m, input logic [3:0] len);
    if (m == 0) begin m0_if.awvalid = 1'b1; m0_if.awlen = len; end
    else        begin m1_if.awvalid = 1'b1; m1_if.awlen = len; end
    step();
    #1;
    chk("aw_valid", s_if.awvalid, 1'b1);
    chk("aw_id_msb", s_if.awid[4], m[0]);
    step();
    m0_if.awvalid = 1'b0;
    m1_if.awvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clr();

    vt[0]  = mkv(1, 1, 0, 5'h00, 10'b0000000000, 5'h00, 32'h0);
    vt[1]  = mkv(1, 1, 0, 5'h00, 10'b1001000000, 5'h03, 32'h0);
    vt[2]  = mkv(1, 1, 0, 5'h00, 10'b0100010000, 5'h00, 32'hA0A0_0000);
    vt[3]  = mkv(1, 1, 1, 5'h03, 10'b0010000100, 5'h00, 32'h0);
    vt[4]  = mkv(1, 1, 0, 5'h00, 10'b0000000000, 5'h00, 32'h0);
    vt[5]  = mkv(1, 1, 0, 5'h00, 10'b1000100000, 5'h15, 32'h0);
    vt[6]  = mkv(1, 1, 0, 5'h00, 10'b0100001000, 5'h00, 32'hB0B0_0000);
    vt[7]  = mkv(1, 1, 1, 5'h15, 10'b0010000010, 5'h00, 32'h0);
    vt[8]  = mkv(1, 1, 0, 5'h00, 10'b0000000000, 5'h00, 32'h0);
    vt[9]  = mkv(1, 1, 0, 5'h00, 10'b1001000000, 5'h03, 32'h0);
    vt[10] = mkv(1, 1, 0, 5'h00, 10'b0100010000, 5'h00, 32'hA0A0_0000);
    vt[11] = mkv(1, 1, 1, 5'h03, 10'b0010000100, 5'h00, 32'h0);
    vt[12] = mkv(1, 1, 0, 5'h00, 10'b0000000000, 5'h00, 32'h0);
    vt[13] = mkv(1, 1, 0, 5'h00, 10'b1000100000, 5'h15, 32'h0);
    vt[14] = mkv(1, 1, 0, 5'h00, 10'b0100001000, 5'h00, 32'hB0B0_0000);
    vt[15] = mkv(1, 1, 1, 5'h15, 10'b0010000010, 5'h00, 32'h0);

    // Round robin, both masters always requesting single-beat writes, slave always ready
    do_reset();
    s_if.awready = 1'b1; s_if.wready = 1'b1;
    m0_if.wvalid = 1'b1; m0_if.wlast = 1'b1; m0_if.bready = 1'b1;
    m1_if.wvalid = 1'b1; m1_if.wlast = 1'b1; m1_if.bready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      m0_if.awvalid = vt[i].aw0;
      m1_if.awvalid = vt[i].aw1;
      s_if.bvalid   = vt[i].bvalid;
      s_if.bid      = vt[i].bid;
      #1;
      chk($sformatf("rr_ctrl[%0d]", i), ctrl(), vt[i].exp_ctrl);
      if (vt[i].exp_ctrl[9]) chk($sformatf("rr_awid[%0d]", i), s_if.awid, vt[i].exp_awid);
      if (vt[i].exp_ctrl[8]) chk($sformatf("rr_wdata[%0d]", i), s_if.wdata, vt[i].exp_wdata);
      step();
    end

    // Burst lock: M0 4-beat burst with one slave stall, M1 pushing W throughout
    do_reset();
    s_if.awready = 1'b1; s_if.wready = 1'b1;
    m1_if.wvalid = 1'b1; m1_if.wdata = 32'hBAD0_BAD0; m1_if.wlast = 1'b1;
    issue_aw(0, 4'd3);
    for (int b = 0; b < 4; b++) begin
      m0_if.wvalid = 1'b1;
      m0_if.wdata  = 32'hC000_0000 + b;
      m0_if.wlast  = (b == 3);
      if (b == 2) begin
        s_if.wready = 1'b0;
        #1;
        chk("burst_stall_wready", {m0_if.wready, m1_if.wready, s_if.wvalid}, 3'b001);
        step();
        s_if.wready = 1'b1;
      end
      #1;
      chk($sformatf("burst_m1_wready[%0d]", b), m1_if.wready, 1'b0);
      chk($sformatf("burst_m0_wready[%0d]", b), m0_if.wready, 1'b1);
      chk($sformatf("burst_wdata[%0d]", b), s_if.wdata, 32'hC000_0000 + b);
      step();
    end
    m0_if.wvalid = 1'b0; m0_if.bready = 1'b1;
    #1;
    chk("burst_in_resp", ctrl(), 10'b0010000000);
    s_if.bvalid = 1'b1; s_if.bid = 5'h03;
    step();
    s_if.bvalid = 1'b0;
    #1;
    chk("burst_done_ctrl", ctrl(), 10'b0);

    // Response routing to M1 with SLVERR
    do_reset();
    s_if.awready = 1'b1; s_if.wready = 1'b1;
    issue_aw(1, 4'd0);
    m1_if.wvalid = 1'b1; m1_if.wlast = 1'b1;
    step();
    m1_if.wvalid = 1'b0;
    s_if.bvalid = 1'b1; s_if.bid = 5'b1_0101; s_if.bresp = RESP_SLVERR;
    #1;
    chk("route_m1_bvalid", m1_if.bvalid, 1'b1);
    chk("route_m1_bid", m1_if.bid, 4'b0101);
    chk("route_m1_bresp", m1_if.bresp, 2'b10);
    chk("route_m0_bvalid", m0_if.bvalid, 1'b0);
    chk("route_bready_held", s_if.bready, 1'b0);
    m1_if.bready = 1'b1;
    #1;
    chk("route_bready", s_if.bready, 1'b1);
    step();
    s_if.bvalid = 1'b0;
    #1;
    chk("route_done_ctrl", ctrl(), 10'b0);

    // Early WLAST on a 2-beat burst; ERR must stick until reset
    do_reset();
    s_if.awready = 1'b1; s_if.wready = 1'b1;
    issue_aw(0, 4'd1);
    m0_if.wvalid = 1'b1; m0_if.wlast = 1'b1;
    #1;
    chk("early_last_pre", err, 1'b0);
    step();
    m0_if.wvalid = 1'b0; m0_if.bready = 1'b1;
    s_if.bvalid = 1'b1; s_if.bid = 5'h03;
    #1;
    chk("early_last_err", ctrl(), 10'b0010000101);
    step();
    s_if.bvalid = 1'b0;
    repeat (3) step();
    chk("err_sticky", err, 1'b1);
    do_reset();
    chk("err_cleared", err, 1'b0);

    // BID MSB disagreeing with the grant
    s_if.awready = 1'b1; s_if.wready = 1'b1;
    issue_aw(0, 4'd0);
    m0_if.wvalid = 1'b1; m0_if.wlast = 1'b1;
    step();
    m0_if.wvalid = 1'b0; m0_if.bready = 1'b1;
    s_if.bvalid = 1'b1; s_if.bid = 5'b1_0011;
    #1;
    chk("bid_mm_pre", {m0_if.bvalid, m1_if.bvalid, err}, 3'b100);
    step();
    s_if.bvalid = 1'b0;
    #1;
    chk("bid_mm_err", err, 1'b1);

    // Missing WLAST on the only beat, then a surplus beat carrying WLAST
    do_reset();
    s_if.awready = 1'b1; s_if.wready = 1'b1;
    issue_aw(0, 4'd0);
    m0_if.wvalid = 1'b1; m0_if.wlast = 1'b0;
    step();
    #1;
    chk("no_last_err", {err, m0_if.wready}, 2'b11);
    m0_if.wlast = 1'b1;
    step();
    m0_if.wvalid = 1'b0; m0_if.bready = 1'b1;
    #1;
    chk("surplus_to_resp", ctrl(), 10'b0010000001);

    // Reset in DATA after one of four beats, then a fresh M1 transaction
    do_reset();
    s_if.awready = 1'b1; s_if.wready = 1'b1;
    issue_aw(0, 4'd3);
    m0_if.wvalid = 1'b1; m0_if.wlast = 1'b0; m0_if.wdata = 32'hD000_0000;
    step();
    #1;
    chk("mid_data_wready", m0_if.wready, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m0_if.wvalid = 1'b0;
    #1;
    chk("mid_rst_idle", ctrl(), 10'b0);
    m1_if.awvalid = 1'b1;
    #1;
    chk("mid_rst_idle_req", ctrl(), 10'b0);
    step();
    #1;
    chk("mid_rst_m1_addr", ctrl(), 10'b1000100000);
    chk("mid_rst_m1_awid", s_if.awid, 5'h15);
    step();
    m1_if.awvalid = 1'b0;
    m1_if.wvalid = 1'b1; m1_if.wlast = 1'b1;
    #1;
    chk("mid_rst_m1_data", ctrl(), 10'b0100001000);
    step();
    m1_if.wvalid = 1'b0; m1_if.bready = 1'b1;
    s_if.bvalid = 1'b1; s_if.bid = 5'h15;
    #1;
    chk("mid_rst_m1_resp", ctrl(), 10'b0010000010);
    step();
    s_if.bvalid = 1'b0;
    #1;
    chk("mid_rst_done", ctrl(), 10'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_wr_arbiter_2to1.md
# axi_wr_arbiter_2to1

Two-master, one-slave AXI write-channel arbiter for the interconnect: it shares a single slave write port (AW/W/B) between two master ports using round-robin grants. Only one write transaction is outstanding at a time. Write data is locked to the granted master until WLAST, and the B response is routed back to the same master. The block also counts write beats against AWLEN and flags protocol mismatches.

## Interface
- DW, 32, write data width.
- AW, 32, address width.
- ID_SIZE, 4, master-side ID width; slave-side ID is ID_SIZE+1.
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-high reset.
- Mn_AWVALID/AWADDR/AWSIZE/AWLEN/AWBURST/AWID  in  1/AW/3/4/2/ID_SIZE  master n (n=0,1) address request.
- Mn_AWREADY  out  1  address accept to master n.
- Mn_WVALID/WDATA/WSTRB/WLAST  in  1/DW/DW/8/1  master n write data.
- Mn_WREADY  out  1  data accept to master n.
- Mn_BVALID/BRESP/BID  out  1/2/ID_SIZE  response to master n.
- Mn_BREADY  in  1  response accept from master n.
- S_AWVALID/AWADDR/AWSIZE/AWLEN/AWBURST/AWID  out  1/AW/3/4/2/ID_SIZE+1  slave address; AWID MSB = grant index.
- S_AWREADY  in  1.
- S_WVALID/WDATA/WSTRB/WLAST  out  1/DW/DW/8/1.
- S_WREADY  in  1.
- S_BVALID/BRESP/BID  in  1/2/ID_SIZE+1.
- S_BREADY  out  1.
- ERR  out  1  sticky protocol error; cleared only by RST.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE
  - If any Mn_AWVALID is high, register `grant` and go to ADDR.
  - If both request, grant the master that is not `last`.
  - Capture AWLEN into `beats_left`, which is 4 bits.
- ADDR
  - S_AW* = granted master's AW*, and S_AWID = {grant, Mn_AWID}.
  - Mgrant_AWREADY = S_AWREADY; the other master's AWREADY = 0.
  - When S_AWVALID && S_AWREADY, go to DATA.
- DATA
  - S_W* is muxed from the granted master, and Mgrant_WREADY = S_WREADY; the other master's WREADY = 0.
  - On each W handshake, decrement `beats_left`.
  - ERR sets if WLAST is high while `beats_left` != 0, or WLAST is low while `beats_left` == 0.
  - A handshake with WLAST high goes to RESP.
- RESP
  - Mgrant_BVALID = S_BVALID, BRESP passes through, and Mgrant_BID = S_BID[ID_SIZE-1:0]; S_BREADY = Mgrant_BREADY.
  - ERR sets if S_BVALID is high and S_BID[ID_SIZE] != grant.
  - On the B handshake, set `last` <= `grant` and go to IDLE.
- Outside its active state, every output VALID/READY is 0. Data and address outputs are muxed from the grant and are don't-care when the corresponding VALID is low.

## Timing
- Reset values: state=IDLE, last=1 (so M0 wins the first tie), grant=0, beats_left=0, ERR=0; all VALID/READY outputs are 0.
- Arbitration latency:
  - Mn_AWVALID high in IDLE at cycle t gives S_AWVALID at t+1.
  - The minimum full single-beat transaction is 4 cycles (IDLE, ADDR, DATA, RESP) plus any slave stalls.
- Handshakes are AXI-compliant. A master's AWVALID rising while the other master is granted waits; it is never dropped.
- W data sent by the non-granted master during DATA is not accepted (WREADY=0).
- A request arriving in the same cycle that B completes is arbitrated in the next IDLE cycle; there is no back-to-back skip of IDLE.
- RST asserted in any state returns the FSM to IDLE on the next edge. The in-flight transaction is abandoned and ERR is cleared.
- beats_left never wraps. An extra beat with beats_left == 0 sets ERR and holds the counter at 0.

## Structure
- Shared package `axi_ic_pkg`:
  - FSM state enum `wr_arb_state_e`.
  - BURST encodings FIXED/INCR/WRAP.
  - RESP encodings OKAY/EXOKAY/SLVERR/DECERR.
- One natural sub-module, `rr_arb2`, a combinational 2-way round-robin picker.
  - Inputs: req[1:0], last. Output: grant.
  - The FSM registers its output in IDLE.

## Test plan
- Reset: RST high for 2 cycles → all VALID/READY outputs 0, ERR=0. The first M0/M1 simultaneous request grants M0, with S_AWID=0_xxxx.
- Round robin: both masters continuously issue AWLEN=0 writes → slave sees M0, M1, M0, M1.
  - AWID MSBs are 0, 1, 0, 1.
  - Each transaction takes 4 cycles with the slave always ready.
- Burst lock: M0 writes AWLEN=3 (4 beats) while M1 drives WVALID → M1_WREADY stays 0 throughout and S_WDATA carries only M0 beats. The arbiter enters RESP after the 4th beat.
- Response routing: slave returns BID=1_0101, BRESP=SLVERR → M1_BVALID=1, M1_BID=0101, M1_BRESP=2'b10, and M0_BVALID stays 0.
- Protocol errors:
  - AWLEN=1 with WLAST on the first beat → ERR=1.
  - Separately, BID MSB mismatching the grant → ERR=1.
  - ERR stays high until RST.
- Mid-transaction reset: assert RST in DATA after 1 of 4 beats → the next cycle is IDLE with all VALID/READY 0, and a new M1 request is granted normally.
